// File: rtl/mem_block_reader_pkg.sv
// Shared types and constants for the memory block reader.
package mem_block_reader_pkg;

    // Controller states: wait for start, hold a read request, present the word, signal completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Largest response delay (in cycles) a test memory is expected to model.
    localparam int unsigned DELAY_MAX = 5;

endpackage

// File: rtl/mem_block_reader.sv
// Block reader: fetches `count` consecutive words starting at `base_addr` from a
// single-outstanding-request memory port and streams them out over val/rdy.
// Optional feature: define MEM_BLOCK_READER_TIMEOUT_EN to add the `err` output and
// abandon a request after TIMEOUT consecutive wait cycles.
module mem_block_reader
    import mem_block_reader_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   count,
    output logic                 busy,
    output logic                 done,
    output logic                 memreq_val,
    output logic [ADDR_BITS-1:0] memreq_addr,
    input  logic                 memresp_wait,
    input  logic [WORD_BITS-1:0] memresp_data,
    output logic                 out_val,
    input  logic                 out_rdy,
`ifdef MEM_BLOCK_READER_TIMEOUT_EN
    output logic [WORD_BITS-1:0] out_data,
    output logic                 err
`else
    output logic [WORD_BITS-1:0] out_data
`endif
);

    state_e                 state_q,  state_d;
    logic [ADDR_BITS-1:0]   addr_q,   addr_d;
    logic [ADDR_BITS:0]     remain_q, remain_d;
    logic [WORD_BITS-1:0]   data_q,   data_d;

`ifdef MEM_BLOCK_READER_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1; the extra bit covers TIMEOUT=1.
    localparam int unsigned          WCNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_BITS-1:0] WCNT_LAST = WCNT_BITS'(TIMEOUT - 1);

    logic [WCNT_BITS-1:0]   wcnt_q, wcnt_d;
    logic                   err_q,  err_d;
`endif

    // Next-state, address/count bookkeeping and response capture.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        data_d   = data_q;
`ifdef MEM_BLOCK_READER_TIMEOUT_EN
        wcnt_d   = '0;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d   = base_addr;
                        remain_d = count;
                        state_d  = REQ;
                    end else begin
                        // Empty block: complete without touching memory.
                        state_d  = DONE;
                    end
                end
            end
            REQ: begin
                if (!memresp_wait) begin
                    data_d  = memresp_data;
                    state_d = OUT;
                end
`ifdef MEM_BLOCK_READER_TIMEOUT_EN
                else if (wcnt_q == WCNT_LAST) begin
                    // Memory never answered: abandon the block silently apart from err.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_BITS'(1);
                end
`endif
            end
            OUT: begin
                if (out_rdy) begin
                    remain_d = remain_q - (ADDR_BITS + 1)'(1);
                    // Natural wrap of the address register gives modulo 2^ADDR_BITS.
                    addr_d   = addr_q + ADDR_BITS'(1);
                    state_d  = (remain_q == (ADDR_BITS + 1)'(1)) ? DONE : REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything the outputs expose.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
        end
    end

`ifdef MEM_BLOCK_READER_TIMEOUT_EN
    // Wait-cycle counter and one-cycle error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`endif

    // All outputs decode directly from registers, so they are glitch-free per cycle.
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign memreq_val  = (state_q == REQ);
    assign memreq_addr = addr_q;
    assign out_val     = (state_q == OUT);
    assign out_data    = data_q;

endmodule

// File: tb/tb_mem_block_reader.sv
// Self-checking bench for mem_block_reader: random memory image, a delayed-response
// memory model, a protocol monitor and directed block scenarios. Covers the
// MEM_BLOCK_READER_TIMEOUT_EN build when that macro is defined.
module tb_mem_block_reader;

    localparam int unsigned AW   = 16;
    localparam int unsigned WW   = 32;
    localparam int unsigned TO   = 8;
    localparam int unsigned DMAX = mem_block_reader_pkg::DELAY_MAX;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          memreq_val;
    logic [AW-1:0] memreq_addr;
    logic          memresp_wait;
    logic [WW-1:0] memresp_data;
    logic          out_val;
    logic          out_rdy;
    logic [WW-1:0] out_data;
`ifdef MEM_BLOCK_READER_TIMEOUT_EN
    logic          err;
`endif

    mem_block_reader #(
        .ADDR_BITS (AW),
        .WORD_BITS (WW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .memreq_val   (memreq_val),
        .memreq_addr  (memreq_addr),
        .memresp_wait (memresp_wait),
        .memresp_data (memresp_data),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
`ifdef MEM_BLOCK_READER_TIMEOUT_EN
        .out_data     (out_data),
        .err          (err)
`else
        .out_data     (out_data)
`endif
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;

    logic [WW-1:0] mem [0:65535];
    int unsigned   mem_delay = 0;
    bit            rdy_rand  = 1'b0;
    logic          rdy_level = 1'b1;

    // Monitor results
    logic [AW-1:0] req_q [$];
    logic [WW-1:0] out_q [$];
    int unsigned   run_q [$];
    int            done_cnt   = 0;
    int            err_cnt    = 0;
    int            viol       = 0;
    int            val_cycles = 0;

    // Monitor history
    logic          pv = 1'b0, pov = 1'b0, prdy = 1'b0, pdone = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [WW-1:0] pdata = '0;
    int unsigned   run   = 0;
    int unsigned   age   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        req_q.delete();
        out_q.delete();
        run_q.delete();
        done_cnt   = 0;
        err_cnt    = 0;
        viol       = 0;
        val_cycles = 0;
    endtask

    // Memory model: answers the open request `mem_delay` cycles after it appears; drives out_rdy.
    initial begin
        memresp_wait = 1'b1;
        memresp_data = '0;
        out_rdy      = 1'b1;
        forever begin
            tick();
            if (memreq_val) begin
                memresp_wait = (age != mem_delay);
                memresp_data = (age == mem_delay) ? mem[memreq_addr] : WW'($urandom);
                age++;
            end else begin
                age          = 0;
                memresp_wait = 1'b1;
                memresp_data = WW'($urandom);
            end
            out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
        end
    end

    // Protocol monitor, sampling mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (memreq_val && !pv) req_q.push_back(memreq_addr);
            if (memreq_val) begin
                run++;
                val_cycles++;
            end else if (pv) begin
                run_q.push_back(run);
                run = 0;
            end
            if (memreq_val && pv && memreq_addr !== paddr) viol++;
            if (memreq_val && (out_val || !busy)) viol++;
            if (out_val && pov && !prdy && out_data !== pdata) viol++;
            if (out_val && out_rdy) out_q.push_back(out_data);
            if (done) begin
                done_cnt++;
                if (pdone) viol++;
            end
`ifdef MEM_BLOCK_READER_TIMEOUT_EN
            if (err) err_cnt++;
`endif
            pv    = memreq_val;
            paddr = memreq_addr;
            pov   = out_val;
            prdy  = out_rdy;
            pdata = out_data;
            pdone = done;
        end
    end

    // One block transaction, checked against the address/data sequence the block must produce.
    task automatic run_block(input string tag, input logic [AW-1:0] base, input int unsigned cnt,
                             input int unsigned delay, input bit poke);
        int unsigned   cyc;
        logic [AW-1:0] a;
        int unsigned   n;
        mem_delay = delay;
        clear_mon();
        start     = 1'b1;
        base_addr = base;
        count     = (AW + 1)'(cnt);
        tick();
        start     = 1'b0;
        base_addr = AW'($urandom);
        count     = (AW + 1)'($urandom);
        cyc = 0;
        while (done_cnt == 0 && cyc < 1000) begin
            if (poke && cyc == 2) begin
                start     = 1'b1;
                base_addr = 16'h1234;
                count     = 17'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        repeat (3) tick();
        check({tag, " done"}, done_cnt, 1);
        check({tag, " nreq"}, req_q.size(), cnt);
        check({tag, " nout"}, out_q.size(), cnt);
        check({tag, " viol"}, viol, 0);
        check({tag, " idle"}, busy, 1'b0);
        n = cnt;
        if (req_q.size() < n) n = req_q.size();
        if (out_q.size() < n) n = out_q.size();
        if (run_q.size() < n) n = run_q.size();
        for (int i = 0; i < int'(n); i++) begin
            a = AW'(base + AW'(i));
            check($sformatf("%s addr%0d", tag, i), req_q[i], a);
            check($sformatf("%s data%0d", tag, i), out_q[i], mem[a]);
            check($sformatf("%s hold%0d", tag, i), run_q[i], delay + 1);
        end
    endtask

    initial begin
        int unsigned   cyc;
        logic [AW-1:0] b;
        logic [WW-1:0] w1;

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        for (int i = 0; i < 65536; i++) mem[i] = WW'($urandom);
        mem[16'h0010] = 32'hA1A1_A1A1;
        mem[16'h0011] = 32'hB2B2_B2B2;
        mem[16'h0012] = 32'hC3C3_C3C3;

        // Reset state while reset is held, then after release.
        repeat (2) @(negedge clk);
        check("rst busy",  busy,        1'b0);
        check("rst done",  done,        1'b0);
        check("rst mval",  memreq_val,  1'b0);
        check("rst maddr", memreq_addr, '0);
        check("rst oval",  out_val,     1'b0);
        check("rst odata", out_data,    '0);
`ifdef MEM_BLOCK_READER_TIMEOUT_EN
        check("rst err",   err,         1'b0);
`endif
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post busy", busy,       1'b0);
        check("post mval", memreq_val, 1'b0);
        tick();

        // Zero-delay block of three known words.
        run_block("blk3", 16'h0010, 3, 0, 1'b0);
        if (out_q.size() == 3) begin
            check("blk3 A", out_q[0], 32'hA1A1_A1A1);
            check("blk3 B", out_q[1], 32'hB2B2_B2B2);
            check("blk3 C", out_q[2], 32'hC3C3_C3C3);
        end else begin
            check("blk3 size", out_q.size(), 3);
        end

        // Slow memory: each request must be held for delay+1 cycles.
        run_block("slow", AW'($urandom), 2, 3, 1'b0);

        // Back-pressure on the first word.
        clear_mon();
        mem_delay = 0;
        rdy_level = 1'b0;
        tick();
        b         = AW'($urandom);
        start     = 1'b1;
        base_addr = b;
        count     = 17'd2;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!out_val && cyc < 50) begin
            tick();
            cyc++;
        end
        check("bp oval", out_val, 1'b1);
        w1 = mem[b];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp data%0d", i), out_data, w1);
            check($sformatf("bp mval%0d", i), memreq_val, 1'b0);
        end
        rdy_level = 1'b1;
        cyc = 0;
        while (done_cnt == 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        tick();
        check("bp done", done_cnt, 1);
        check("bp nout", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("bp w1", out_q[0], w1);
            check("bp w2", out_q[1], mem[AW'(b + 1)]);
        end
        check("bp viol", viol, 0);

        // Address wrap, with a start pulse while busy that must be ignored.
        run_block("wrap", 16'hFFFF, 2, 2, 1'b1);

        // Empty block: done one cycle after start, no request.
        clear_mon();
        start     = 1'b1;
        base_addr = 16'h0055;
        count     = '0;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zero done", done,       1'b1);
        check("zero busy", busy,       1'b1);
        check("zero mval", memreq_val, 1'b0);
        tick();
        @(negedge clk);
        check("zero done2", done, 1'b0);
        check("zero busy2", busy, 1'b0);
        check("zero nreq",  req_q.size(), 0);
        check("zero ndone", done_cnt, 1);
        tick();

        // Reset between clock edges in the middle of a request.
        clear_mon();
        mem_delay = 10;
        start     = 1'b1;
        base_addr = AW'($urandom);
        count     = 17'd4;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("mid mval pre", memreq_val, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("mid mval",  memreq_val, 1'b0);
        check("mid busy",  busy,       1'b0);
        check("mid oval",  out_val,    1'b0);
        check("mid odata", out_data,   '0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("mid done", done_cnt, 0);
        run_block("afterrst", AW'($urandom), 3, 1, 1'b0);

        // Random blocks with random consumer back-pressure.
        rdy_rand = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_block($sformatf("rnd%0d", k), AW'($urandom), $urandom_range(1, 5),
                      $urandom_range(0, DMAX), 1'b0);
        end
        rdy_rand = 1'b0;
        tick();

`ifdef MEM_BLOCK_READER_TIMEOUT_EN
        // Memory slower than the timeout: err pulse, back to IDLE, no done.
        clear_mon();
        mem_delay = 20;
        start     = 1'b1;
        base_addr = AW'($urandom);
        count     = 17'd2;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check("to err",   err_cnt,      1);
        check("to done",  done_cnt,     0);
        check("to reqcy", val_cycles,   TO);
        check("to nreq",  req_q.size(), 1);
        check("to busy",  busy,         1'b0);
        run_block("aftertmo", AW'($urandom), 2, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
